// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and default width for the iterative RV32M multiply/divide unit
package muldiv_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} muldiv_op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration; acc_i/opd_i/div_i in, next acc_o and quotient bit q_o out
module muldiv_step import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opd_i,
  input  logic              div_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_o
);
  logic [XLEN:0]   sum;
  logic [XLEN:0]   sh;
  logic [XLEN-1:0] diff;
  logic            ge;
  always_comb begin
    sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opd_i} : '0);
    sh    = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    ge    = sh >= {1'b0, opd_i};
    diff  = sh[XLEN-1:0] - opd_i;
    q_o   = div_i & ge;
    acc_o = div_i ? {ge ? diff : sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0} : {sum, acc_i[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M mul/div sequencer (clk, reset, StartE, FunctE, SrcAE, SrcBE, FlushE -> MulBusy, MulDone, MulResult); MULDIV_FASTPATH_EN skips RUN for trivial operands
module muldiv_seq import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      FunctE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            MulBusy,
  output logic            MulDone,
  output logic [XLEN-1:0] MulResult
);
  localparam int CW = $clog2(XLEN);
  muldiv_state_t     state_q, state_d;
  muldiv_op_t        op_q, op_d, op_in;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, acc_nx, mul_fix, start_acc;
  logic [XLEN-1:0]   opd_q, opd_d, res_q, res_d, a_abs, b_abs, div_half, div_fix, fin_res, fast_res;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d, q_bit, a_neg, b_neg, b_zero, start_neg, accept, fast;
  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i(acc_q),
    .opd_i(opd_q),
    .div_i(op_q[2]),
    .acc_o(acc_step),
    .q_o  (q_bit)
  );
  always_comb begin
    op_in     = muldiv_op_t'(FunctE);
    a_neg     = (op_in inside {MULH, MULHSU, DIV, REM}) & SrcAE[XLEN-1];
    b_neg     = (op_in inside {MULH, DIV, REM}) & SrcBE[XLEN-1];
    a_abs     = a_neg ? -SrcAE : SrcAE;
    b_abs     = b_neg ? -SrcBE : SrcBE;
    b_zero    = ~|SrcBE;
    start_neg = !op_in[2] ? a_neg ^ b_neg : (op_in inside {REM, REMU}) ? a_neg : (a_neg ^ b_neg) & !b_zero;
    start_acc = {{XLEN{1'b0}}, op_in[2] ? a_abs : b_abs};
    accept    = StartE & !FlushE & (state_q != RUN);
    acc_nx    = acc_step | {{(2*XLEN-1){1'b0}}, q_bit};
    mul_fix   = neg_q ? -acc_nx : acc_nx;
    div_half  = (op_q inside {DIV, DIVU}) ? acc_nx[XLEN-1:0] : acc_nx[2*XLEN-1:XLEN];
    div_fix   = neg_q ? -div_half : div_half;
    fin_res   = op_q[2] ? div_fix : (op_q == MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_FASTPATH_EN
    fast      = op_in[2] ? b_zero | ((op_in inside {DIV, REM}) & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & &SrcBE) : b_zero | ~|SrcAE;
    fast_res  = !op_in[2] ? '0 : b_zero ? ((op_in inside {REM, REMU}) ? SrcAE : '1) : ((op_in inside {REM, REMU}) ? '0 : SrcAE);
`else
    fast      = 1'b0;
    fast_res  = '0;
`endif
    MulBusy   = accept | (state_q == RUN);
    MulDone   = state_q == DONE;
    MulResult = res_q;
  end
  always_comb begin
    state_d = (state_q == RUN) ? ((cnt_q == '0) ? DONE : RUN) : IDLE;
    op_d    = op_q;
    acc_d   = (state_q == RUN) ? acc_nx : acc_q;
    opd_d   = opd_q;
    cnt_d   = (state_q == RUN && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    neg_d   = neg_q;
    res_d   = (state_q == RUN && cnt_q == '0) ? fin_res : res_q;
    if (accept) begin
      state_d = fast ? DONE : RUN;
      op_d    = op_in;
      acc_d   = start_acc;
      opd_d   = op_in[2] ? b_abs : a_abs;
      cnt_d   = CW'(XLEN - 1);
      neg_d   = start_neg;
      res_d   = fast ? fast_res : res_q;
    end
    if (FlushE) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MUL;
      acc_q   <= '0;
      opd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end
endmodule
